// File: rtl/ws2811_serial_rx_pkg.sv
// Shared WS2811 constants and the receiver state encoding.
package ws2811_serial_rx_pkg;

    localparam int WS2811_WORD_BITS = 24;

    // Default line timing in clk cycles at 50 MHz, shared with the transmitter.
    localparam int T0H       = 12;
    localparam int T1H       = 30;
    localparam int T0L       = 50;
    localparam int T1L       = 32;
    localparam int RESET_LOW = 2500;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIGH = 3'd1,
        ST_LOW  = 3'd2,
        ST_PASS = 3'd3,
        ST_ERR  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/ws2811_serial_rx_pulse_meter.sv
// Synchronizes the WS2811 line, detects edges and measures high/low run lengths.
module ws2811_serial_rx_pulse_meter #(
    parameter int MAX_HIGH  = 80,
    parameter int RESET_LOW = 2500,
    parameter int CNT_W     = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    output logic             s,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] lcnt
);

    logic s_meta;
    logic s_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            s_meta <= serial_in;
            s      <= s_meta;
            s_d    <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // At a fall, hcnt equals the width of the high run; at a rise, lcnt the low run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            if (rise)
                hcnt <= CNT_W'(1);
            else if (!s)
                hcnt <= '0;
            else if (hcnt != CNT_W'(MAX_HIGH))
                hcnt <= hcnt + CNT_W'(1);

            if (fall)
                lcnt <= CNT_W'(1);
            else if (s)
                lcnt <= '0;
            else if (lcnt != CNT_W'(RESET_LOW))
                lcnt <= lcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ws2811_serial_rx.sv
// WS2811 pixel emulator: captures the first 24-bit word after a latch gap,
// then repeats the rest of the frame on serial_out.
//
//   state | meaning
//   IDLE  | waiting for the first rising edge of a frame
//   HIGH  | measuring a data high pulse
//   LOW   | between bits of our own word, watching for a latch gap
//   PASS  | word captured, forwarding the line downstream
//   ERR   | timing violation seen, ignoring the line until a latch gap
module ws2811_serial_rx
    import ws2811_serial_rx_pkg::*;
#(
    parameter int BIT_THRESH = 21,
    parameter int MIN_HIGH   = 4,
    parameter int MAX_HIGH   = 80,
    parameter int RESET_LOW  = ws2811_serial_rx_pkg::RESET_LOW,
    parameter int CNT_W      = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_in,
    output logic [23:0] rgb_data,
    output logic        word_valid,
    output logic        latch,
    output logic        serial_out,
    output logic        bit_error,
    output logic        db_serial
);

    logic             s;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;

    rx_state_t   state, state_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [22:0] shift_reg, shift_nxt;
    logic [23:0] rgb_nxt;
    logic        word_valid_nxt;
    logic        latch_nxt;
    logic        serial_out_nxt;
    logic        bit_error_nxt;
    logic        err_set;
    logic        err_clr;
    logic        bit_val;
    logic        gap_done;

    ws2811_serial_rx_pulse_meter #(
        .MAX_HIGH (MAX_HIGH),
        .RESET_LOW(RESET_LOW),
        .CNT_W    (CNT_W)
    ) u_meter (
        .clock    (clock),
        .reset    (reset),
        .serial_in(serial_in),
        .s        (s),
        .rise     (rise),
        .fall     (fall),
        .hcnt     (hcnt),
        .lcnt     (lcnt)
    );

    assign db_serial = s;
    assign bit_val   = (hcnt >= CNT_W'(BIT_THRESH));
    assign gap_done  = (lcnt == CNT_W'(RESET_LOW));

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift_reg;
        rgb_nxt        = rgb_data;
        word_valid_nxt = 1'b0;
        latch_nxt      = 1'b0;
        serial_out_nxt = 1'b0;
        err_set        = 1'b0;
        err_clr        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                bit_cnt_nxt = '0;
                if (rise)
                    state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (hcnt == CNT_W'(MAX_HIGH)) begin
                    err_set   = 1'b1;
                    state_nxt = ST_ERR;
                end else if (fall) begin
                    if (hcnt < CNT_W'(MIN_HIGH)) begin
                        err_set   = 1'b1;
                        state_nxt = ST_ERR;
                    end else begin
                        shift_nxt   = {shift_reg[21:0], bit_val};
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'(WS2811_WORD_BITS - 1)) begin
                            rgb_nxt        = {shift_reg, bit_val};
                            word_valid_nxt = 1'b1;
                            state_nxt      = ST_PASS;
                        end else begin
                            state_nxt = ST_LOW;
                        end
                    end
                end
            end
            ST_LOW: begin
                // The gap wins over a coincident rise; that rise is dropped.
                if (gap_done) begin
                    latch_nxt   = 1'b1;
                    err_clr     = 1'b1;
                    err_set     = (bit_cnt != 5'd0);
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_IDLE;
                end else if (rise) begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_PASS: begin
                serial_out_nxt = s;
                if (gap_done) begin
                    latch_nxt = 1'b1;
                    err_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (gap_done) begin
                    latch_nxt = 1'b1;
                    err_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        bit_error_nxt = err_set | (bit_error & ~err_clr);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rgb_data   <= '0;
            word_valid <= 1'b0;
            latch      <= 1'b0;
            serial_out <= 1'b0;
            bit_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            rgb_data   <= rgb_nxt;
            word_valid <= word_valid_nxt;
            latch      <= latch_nxt;
            serial_out <= serial_out_nxt;
            bit_error  <= bit_error_nxt;
        end
    end

endmodule
